// File: rtl/sram_req_bridge_if.sv
// Request/response handshake bundle between a requester and the SRAM bridge.
// The master modport is the requester side and the slave modport is the bridge side.
interface sram_req_bridge_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [3:0]  req_be;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_be, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_be, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/sram_req_bridge.sv
// Valid/ready front end for a 1-cycle-latency single-port word SRAM macro.
// Accepted requests strobe the macro directly; responses queue in order with back-pressure.
module sram_req_bridge #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MEM_AW    = 12,
    parameter int unsigned RSP_DEPTH = 3
) (
    input  logic              CLK,
    input  logic              RST,
    sram_req_bridge_if.slave  bus,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [31:0]       ram_di,
    output logic [MEM_AW-1:0] ram_a,
    input  logic [31:0]       ram_do
);
    localparam int unsigned   PW       = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int unsigned   CW       = $clog2(RSP_DEPTH + 1);
    localparam logic [PW-1:0] LAST_IDX = PW'(RSP_DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(RSP_DEPTH);

    logic [PW-1:0] wr_ptr, rd_ptr, pend_idx;
    logic [CW-1:0] count;
    logic          pend;
    logic          ent_err  [RSP_DEPTH];
    logic          ent_ok   [RSP_DEPTH];
    logic [31:0]   ent_data [RSP_DEPTH];

    logic err, acc, mem_acc, pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == LAST_IDX) ? '0 : p + 1'b1;
    endfunction

    assign err = (bus.req_addr[1:0] != 2'b00)
               | (bus.req_addr[31:MEM_AW+2] != BASE_ADDR[31:MEM_AW+2]);

    // Credit depends only on queue occupancy, never on the response handshake.
    assign bus.req_ready = !RST && (count < DEPTH_C);
    assign acc           = bus.req_valid & bus.req_ready;
    assign mem_acc       = acc & !err;

    assign ram_en = mem_acc;
    assign ram_we = (mem_acc & bus.req_we) ? bus.req_be : 4'h0;
    assign ram_a  = bus.req_addr[MEM_AW+1:2];
    assign ram_di = bus.req_wdata;

    assign bus.rsp_valid = (count != '0) & ent_ok[rd_ptr];
    assign bus.rsp_rdata = bus.rsp_valid ? ent_data[rd_ptr] : 32'h0;
    assign bus.rsp_err   = bus.rsp_valid & ent_err[rd_ptr];
    assign pop           = bus.rsp_valid & bus.rsp_ready;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            pend_idx <= '0;
            count    <= '0;
            pend     <= 1'b0;
            for (int i = 0; i < int'(RSP_DEPTH); i++) begin
                ent_err[i]  <= 1'b0;
                ent_ok[i]   <= 1'b0;
                ent_data[i] <= 32'h0;
            end
        end else begin
            if (acc) begin
                ent_err[wr_ptr]  <= err;
                ent_data[wr_ptr] <= 32'h0;
                ent_ok[wr_ptr]   <= err | bus.req_we;
                wr_ptr           <= bump(wr_ptr);
            end
            // The pending slot is still occupied, so it never aliases the new allocation.
            if (pend) begin
                ent_data[pend_idx] <= ram_do;
                ent_ok[pend_idx]   <= 1'b1;
            end
            pend     <= mem_acc & !bus.req_we;
            pend_idx <= wr_ptr;
            if (pop) begin
                rd_ptr <= bump(rd_ptr);
            end
            if (acc && !pop) begin
                count <= count + 1'b1;
            end else if (!acc && pop) begin
                count <= count - 1'b1;
            end
        end
    end
endmodule

// File: doc/sram_req_bridge.md
Name: sram_req_bridge

Overview:
- Valid/ready request-response front end for the 4096 x 32 single-port DFFRAM macro. Sits directly upstream of the macro.
- Converts byte-addressed word requests from the core/bus side into macro EN/WE/Di/A strobes.
- Captures the macro's 1-cycle-latency Do into an in-order response queue, so the requester sees back-pressurable responses.
- Flags misaligned and out-of-window accesses as errors without touching the macro.

Parameters:
- BASE_ADDR, 32'h0000_0000: byte base address of the RAM window; must be 16 KiB aligned.
- MEM_AW, 12: macro word-address width (window = 4 * 2^MEM_AW bytes).
- RSP_DEPTH, 3: response queue entries; 3 is the minimum for one request per cycle with rsp_ready held high; legal range 3..8.

Ports:
- CLK  in  1  clock; the single clock, shared with the macro.
- RST  in  1  asynchronous, active-high reset.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when req_valid & req_ready at a CLK rising edge.
- req_we  in  1  1 = write, 0 = read.
- req_be  in  4  byte enables for writes; ignored for reads.
- req_addr  in  32  byte address.
- req_wdata  in  32  write data.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready.
- rsp_rdata  out  32  read data; 0 for writes and for errors.
- rsp_err  out  1  1 = misaligned or out-of-window access.
- ram_en  out  1  macro chip enable.
- ram_we  out  4  macro byte write mask.
- ram_di  out  32  macro data in.
- ram_a  out  MEM_AW  macro word address.
- ram_do  in  32  macro data out; valid the cycle after ram_en.

Behaviour:
- Accept: acc = req_valid & req_ready. Requests complete strictly in order; every accepted request yields exactly one response.
- Error check (combinational on req_addr):
  - err = (req_addr[1:0] != 0) | (req_addr[31:MEM_AW+2] != BASE_ADDR[31:MEM_AW+2]).
- Macro drive (combinational):
  - ram_en = acc & !err.
  - ram_we = (acc & !err & req_we) ? req_be : 4'h0.
  - ram_a = req_addr[MEM_AW+1:2].
  - ram_di = req_wdata.
- Writes with req_be = 4'h0 still pulse ram_en and return an ok response; memory is unchanged.
- Response queue: RSP_DEPTH entries of {we, err, data, data_ok}, circular rd/wr pointers plus an occupancy count.
  - Allocation on acc at edge N: entry written with we and err, data = 0.
    - Reads with err = 0: data_ok = 0.
    - All other requests: data_ok = 1.
  - Fill: a one-cycle pending flag and pending index track the outstanding read. At edge N+1 the entry's data is loaded from ram_do and data_ok is set.
- Ready and credit rules:
  - req_ready = !RST & (count < RSP_DEPTH).
  - No combinational path from rsp_ready or rsp_valid to req_ready.
- Outputs:
  - rsp_valid = (count != 0) & head.data_ok.
  - rsp_rdata = rsp_valid ? head.data : 0.
  - rsp_err = rsp_valid & head.err.
- Pop: on rsp_valid & rsp_ready at an edge. Push and pop in the same cycle leave count unchanged; pointers wrap modulo RSP_DEPTH.
- Latency:
  - Read accepted at edge N: rsp_valid from cycle N+2 (after edge N+1).
  - Write or error accepted at edge N: rsp_valid from cycle N+1.
  - A write followed by a read to the same address returns the new data; the macro sequences these naturally.
- Throughput: with rsp_ready held high, back-to-back reads are accepted every cycle and responses stream every cycle after the 2-cycle fill.
- Back-pressure: with rsp_ready low, req_ready drops once RSP_DEPTH requests are outstanding. ram_do is captured at the fixed N+1 edge regardless of rsp_ready, so data is never lost.
- Reset:
  - RST asserted at any time asynchronously clears count, pointers, pending flag and all data_ok bits.
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
  - req_ready = 0 and ram_en = 0 while RST is high.
  - In-flight requests are discarded with no response. A macro write strobed in the same cycle RST rises is suppressed, because ram_en is gated by req_ready.
- Held inputs: req_* may change freely when req_valid = 0. Requests presented while req_ready = 0 are not consumed.

Test Plan:
- Reset, then write addr 0x10, be 4'hF, wdata 0xDEADBEEF, rsp_ready = 1 -> ram_en = 1, ram_we = 4'hF, ram_a = 4 in the accept cycle; rsp_valid in the next cycle with err 0, rdata 0. A subsequent read of 0x10 -> rdata 0xDEADBEEF, 2 cycles after accept.
- Byte write be 4'b0100, wdata 0x00AA0000 to 0x10 after the above, then read -> 0xDEAABEEF.
- Read addr 0x13 (misaligned) and read addr BASE_ADDR + 0x4000 (out of window) -> ram_en stays 0; each gets rsp_err = 1, rdata 0, 1 cycle after accept.
- 8 back-to-back reads of words 0..7 (preloaded 0x100+i), rsp_ready = 1 -> req_ready constant 1; 8 consecutive rsp_valid cycles with data 0x100..0x107 in order.
- rsp_ready = 0 while issuing 5 reads -> exactly 3 accepted, then req_ready = 0. rsp_ready = 1 -> 3 correct responses drain in order, and the remaining 2 are then accepted.
- Assert RST for 1 cycle with 2 reads outstanding -> rsp_valid, rsp_err, rsp_rdata go 0 immediately and req_ready = 0 during reset; no stale response appears after release; next read returns correct data.
